serial_byte_tx: RTL and testbench
=================================

SERIAL_BYTE_TX -- requirements
Module: serial_byte_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the parallel word width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 is sent first, 0 = bit 0 is sent first.
REQ-003 The block SHALL have parameter IDLE_LEVEL, default 1'b0, giving the s_out level when no word is being sent.
REQ-004 The block SHALL have port clk, input, 1 bit: single system clock, rising-edge active.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port tick, input, 1 bit: one-clk-wide bit-rate strobe from the clock divider.
REQ-007 The block SHALL have port din, input, WIDTH bits: parallel word to serialize.
REQ-008 The block SHALL have port load_valid, input, 1 bit: din holds a word to send.
REQ-009 The block SHALL have port load_ready, output, 1 bit: the block accepts din this cycle.
REQ-010 The block SHALL have port s_out, output, 1 bit: serial data stream for the downstream SIPO s_in.
REQ-011 The block SHALL have port busy, output, 1 bit: a word is captured and not yet fully sent.
REQ-012 The block SHALL have port done, output, 1 bit: one-clk pulse when the last bit period ends.

Function
REQ-013 The FSM SHALL have three states: IDLE, ARM and SHIFT; all outputs SHALL be registered or decoded from registered state only.
REQ-014 In IDLE: load_ready = 1, busy = 0, s_out = IDLE_LEVEL.
REQ-015 In IDLE, load_valid=1 SHALL capture din into the shift register, clear the bit counter and move to ARM; capture occurs regardless of tick.
REQ-016 In ARM, the first tick SHALL drive s_out to the first bit (per MSB_FIRST), set count = 0 and move to SHIFT.
REQ-017 In SHIFT, each tick with count < WIDTH-1 SHALL drive s_out to the next bit and increment count.
REQ-018 In SHIFT, a tick with count == WIDTH-1 SHALL drive s_out to IDLE_LEVEL, pulse done for exactly one clk and return to IDLE.
REQ-019 Each data bit SHALL be held on s_out for exactly one tick interval.
REQ-020 Latency: the first bit SHALL appear 1 clk after the first tick following capture; done SHALL assert 1 clk after the (WIDTH+1)-th tick following capture.
REQ-021 In ARM and SHIFT: load_ready = 0 and busy = 1; load_valid and din SHALL be ignored.
REQ-022 Boundary cases:
- A tick in IDLE SHALL have no effect.
- A tick coincident with a capture in IDLE SHALL NOT count as the ARM tick.
- A tick with no clk-edge change in load_valid SHALL have no side effects.
- Bursts are not required.
REQ-023 The counter SHALL be $clog2(WIDTH) bits wide and SHALL never exceed WIDTH-1; no wrap-around past WIDTH-1 is allowed.
REQ-024 Back-to-back operation: a new word SHALL be accepted in the clk cycle after done, giving one idle tick gap minimum at line level.

Reset
REQ-025 Asserting rst_n=0 SHALL immediately, without waiting for clk:
- force state to IDLE;
- set s_out = IDLE_LEVEL, done = 0, busy = 0, load_ready = 1;
- clear the counter and shift register.
REQ-026 Reset mid-word SHALL abort the word with no done pulse; the first accepted word after release SHALL be sent complete.

Structure
REQ-027 The state encodings (IDLE=2'd0, ARM=2'd1, SHIFT=2'd2) and the default WIDTH/IDLE_LEVEL values SHALL live in the shared package serial_pkg.
REQ-028 The block SHALL be a single module with no sub-module; tick SHALL come from the existing 1 Hz divider instance in the top level.

Verification
REQ-029 Load din=8'hA5 with MSB_FIRST=1 and tick every 4 clk -> s_out = 1,0,1,0,0,1,0,1, each bit for 4 clk, then IDLE_LEVEL; done pulses once; a SIPO fed from s_out holds 8'hA5.
REQ-030 Set MSB_FIRST=0 and load din=8'h01 -> s_out = 1 followed by seven 0s.
REQ-031 Load 8'hFF, then assert load_valid with din=8'h00 during SHIFT -> load_ready=0; the output stays 8 ones; 8'h00 is never sent.
REQ-032 Assert tick in the same clk as the capture of 8'h80 -> the first bit appears only after the next tick; 8 bit periods are still produced.
REQ-033 Pull rst_n low after the 3rd bit of 8'hC3 -> s_out=IDLE_LEVEL and busy=0 asynchronously, no done pulse; the next word 8'h3C is sent intact.
REQ-034 Send 8'h55 and 8'hAA back-to-back with load_valid held high -> the second capture occurs in the clk after done; both words are sent correctly.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial byte transmitter.
//   tx_state_e      : FSM state encoding (IDLE=0, ARM=1, SHIFT=2)
//   DEF_WIDTH       : default parallel word width
//   DEF_IDLE_LEVEL  : default line level while no word is being sent
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        SHIFT = 2'd2
    } tx_state_e;

    localparam int   DEF_WIDTH      = 8;
    localparam logic DEF_IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/serial_byte_tx_if.sv
// Load/serial-line bundle between a word producer and serial_byte_tx.
//   tick       : one-clk bit-rate strobe from the clock divider
//   din        : parallel word to serialize
//   load_valid : din holds a word to send
//   load_ready : transmitter accepts din this cycle
//   s_out      : serial data stream toward the downstream SIPO
//   busy       : a word is captured and not yet fully sent
//   done       : one-clk pulse when the last bit period ends
// master = producer side, slave = transmitter side.
interface serial_byte_tx_if
    import serial_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic             tick;
    logic [WIDTH-1:0] din;
    logic             load_valid;
    logic             load_ready;
    logic             s_out;
    logic             busy;
    logic             done;

    modport master (
        output tick, din, load_valid,
        input  load_ready, s_out, busy, done
    );

    modport slave (
        input  tick, din, load_valid,
        output load_ready, s_out, busy, done
    );

endinterface

// File: rtl/serial_byte_tx.sv
// Parallel-to-serial word transmitter paced by an external bit-rate tick.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : serial_byte_tx_if.slave (tick, din, load_valid in;
//           load_ready, s_out, busy, done out)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | line at IDLE_LEVEL, load_ready=1, waiting for load_valid
// ARM   | word captured, waiting for the first tick to start bit 0
// SHIFT | a data bit is on the line; count = index of the bit shown
module serial_byte_tx
    import serial_pkg::*;
#(
    parameter int   WIDTH      = DEF_WIDTH,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = DEF_IDLE_LEVEL
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_byte_tx_if.slave   bus
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    tx_state_e        r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CNT_W-1:0] r_count;
    logic             r_s_out;
    logic             r_done;

    tx_state_e        w_state_nxt;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_s_out_nxt;
    logic             w_done_nxt;

    logic             w_head;
    logic [WIDTH-1:0] w_shifted;

    // The bit to put on the line next always sits at the head of the
    // shift register; shifting after each emit brings up the following one.
    assign w_head    = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
    assign w_shifted = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0}
                                 : {1'b0, r_shift[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_count <= '0;
            r_s_out <= IDLE_LEVEL;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_count <= w_count_nxt;
            r_s_out <= w_s_out_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_count_nxt = r_count;
        w_s_out_nxt = r_s_out;
        w_done_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                w_s_out_nxt = IDLE_LEVEL;
                // Capture ignores tick, so a tick on the capture edge is
                // not mistaken for the ARM tick.
                if (bus.load_valid) begin
                    w_shift_nxt = bus.din;
                    w_count_nxt = '0;
                    w_state_nxt = ARM;
                end
            end
            ARM: begin
                if (bus.tick) begin
                    w_s_out_nxt = w_head;
                    w_shift_nxt = w_shifted;
                    w_count_nxt = '0;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.tick) begin
                    if (r_count == CNT_LAST) begin
                        w_s_out_nxt = IDLE_LEVEL;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_s_out_nxt = w_head;
                        w_shift_nxt = w_shifted;
                        w_count_nxt = r_count + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_s_out_nxt = IDLE_LEVEL;
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.load_ready = (r_state == IDLE);
    assign bus.busy       = (r_state != IDLE);
    assign bus.s_out      = r_s_out;
    assign bus.done       = r_done;

endmodule

// File: tb/tb_serial_byte_tx.sv
// Directed bench for serial_byte_tx: an MSB-first instance (idle low) and an
// LSB-first instance (idle high) receive identical stimulus.
module tb_serial_byte_tx;

    localparam logic IDLE0 = 1'b0;
    localparam logic IDLE1 = 1'b1;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic [7:0] din;
    logic       load_valid;

    int n_tests;
    int n_fail;
    int n_done0;
    int n_done1;
    int base0;
    int base1;

    serial_byte_tx_if #(.WIDTH(8)) if0 ();
    serial_byte_tx_if #(.WIDTH(8)) if1 ();

    assign if0.tick       = tick;
    assign if0.din        = din;
    assign if0.load_valid = load_valid;
    assign if1.tick       = tick;
    assign if1.din        = din;
    assign if1.load_valid = load_valid;

    serial_byte_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(IDLE0)) u_dut_msb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );

    serial_byte_tx #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(IDLE1)) u_dut_lsb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (if0.done) n_done0 = n_done0 + 1;
        if (if1.done) n_done1 = n_done1 + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [7:0] w);
        din        = w;
        load_valid = 1'b1;
        clk1();
        load_valid = 1'b0;
        base0 = n_done0;
        base1 = n_done1;
    endtask

    // Runs nbits tick periods of 4 clk each starting from ARM and checks the
    // line every clk; with nbits==8 it also issues the closing tick and stops
    // in the cycle where done should be high.
    task automatic send_check(input logic [7:0] w, input int nbits, input string tag);
        logic [7:0] sipo0;
        logic [7:0] sipo1;
        sipo0 = '0;
        sipo1 = '0;
        for (int k = 0; k < nbits; k++) begin
            tick = 1'b1;
            clk1();
            tick = 1'b0;
            sipo0 = {sipo0[6:0], if0.s_out};
            sipo1 = {if1.s_out, sipo1[7:1]};
            for (int j = 0; j < 4; j++) begin
                if (j > 0) clk1();
                check_val({tag, "_msb_bit"}, {31'd0, if0.s_out}, {31'd0, w[7-k]});
                check_val({tag, "_lsb_bit"}, {31'd0, if1.s_out}, {31'd0, w[k]});
                if (j == 0) begin
                    check_val({tag, "_busy"},  {31'd0, if0.busy},       32'd1);
                    check_val({tag, "_ready"}, {31'd0, if0.load_ready}, 32'd0);
                    check_val({tag, "_done"},  {30'd0, if0.done, if1.done}, 32'd0);
                end
            end
        end
        if (nbits == 8) begin
            check_val({tag, "_sipo_msb"}, {24'd0, sipo0}, {24'd0, w});
            check_val({tag, "_sipo_lsb"}, {24'd0, sipo1}, {24'd0, w});
            tick = 1'b1;
            clk1();
            tick = 1'b0;
            check_val({tag, "_end_line0"}, {31'd0, if0.s_out}, {31'd0, IDLE0});
            check_val({tag, "_end_line1"}, {31'd0, if1.s_out}, {31'd0, IDLE1});
            check_val({tag, "_done_hi"},   {30'd0, if0.done, if1.done}, 32'd3);
            check_val({tag, "_end_busy"},  {30'd0, if0.busy, if1.busy}, 32'd0);
            check_val({tag, "_end_ready"}, {31'd0, if0.load_ready}, 32'd1);
        end
    endtask

    task automatic finish_word(input string tag, input int exp_done);
        clk1();
        check_val({tag, "_done_lo"},   {30'd0, if0.done, if1.done}, 32'd0);
        check_val({tag, "_idle_busy"}, {30'd0, if0.busy, if1.busy}, 32'd0);
        check_val({tag, "_ndone0"},    n_done0 - base0, exp_done);
        check_val({tag, "_ndone1"},    n_done1 - base1, exp_done);
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        n_done0    = 0;
        n_done1    = 0;
        base0      = 0;
        base1      = 0;
        rst_n      = 1'b1;
        tick       = 1'b0;
        din        = 8'h00;
        load_valid = 1'b0;

        #1 rst_n = 1'b0;
        #1;
        check_val("rst_line0", {31'd0, if0.s_out},      {31'd0, IDLE0});
        check_val("rst_line1", {31'd0, if1.s_out},      {31'd0, IDLE1});
        check_val("rst_busy",  {30'd0, if0.busy, if1.busy}, 32'd0);
        check_val("rst_ready", {30'd0, if0.load_ready, if1.load_ready}, 32'd3);
        check_val("rst_done",  {30'd0, if0.done, if1.done}, 32'd0);
        clk1();
        clk1();
        rst_n = 1'b1;
        clk1();

        // Tick while idle must not start anything.
        tick = 1'b1;
        clk1();
        tick = 1'b0;
        check_val("idle_tick_busy",  {30'd0, if0.busy, if1.busy}, 32'd0);
        check_val("idle_tick_line0", {31'd0, if0.s_out}, {31'd0, IDLE0});
        check_val("idle_tick_ready", {31'd0, if0.load_ready}, 32'd1);

        // A5: basic MSB/LSB serialization.
        load_word(8'hA5);
        check_val("a5_arm_busy",  {30'd0, if0.busy, if1.busy}, 32'd3);
        check_val("a5_arm_line0", {31'd0, if0.s_out}, {31'd0, IDLE0});
        send_check(8'hA5, 8, "a5");
        finish_word("a5", 1);

        // 01: LSB-first instance shows 1 then seven 0s.
        load_word(8'h01);
        send_check(8'h01, 8, "w01");
        finish_word("w01", 1);

        // FF with a competing 00 load held during the whole word.
        load_word(8'hFF);
        din        = 8'h00;
        load_valid = 1'b1;
        clk1();
        check_val("ff_ignore_ready", {31'd0, if0.load_ready}, 32'd0);
        send_check(8'hFF, 8, "ff");
        load_valid = 1'b0;
        finish_word("ff", 1);

        // Tick on the capture edge of 80 does not arm the transmission.
        din        = 8'h80;
        load_valid = 1'b1;
        tick       = 1'b1;
        clk1();
        load_valid = 1'b0;
        tick       = 1'b0;
        base0 = n_done0;
        base1 = n_done1;
        for (int j = 0; j < 4; j++) begin
            check_val("t80_wait_line0", {31'd0, if0.s_out}, {31'd0, IDLE0});
            check_val("t80_wait_line1", {31'd0, if1.s_out}, {31'd0, IDLE1});
            check_val("t80_wait_busy",  {31'd0, if0.busy}, 32'd1);
            clk1();
        end
        send_check(8'h80, 8, "t80");
        finish_word("t80", 1);

        // Reset after the 3rd bit of C3 aborts without done.
        load_word(8'hC3);
        send_check(8'hC3, 3, "c3");
        rst_n = 1'b0;
        #1;
        check_val("c3_rst_line0", {31'd0, if0.s_out}, {31'd0, IDLE0});
        check_val("c3_rst_line1", {31'd0, if1.s_out}, {31'd0, IDLE1});
        check_val("c3_rst_busy",  {30'd0, if0.busy, if1.busy}, 32'd0);
        check_val("c3_rst_ready", {30'd0, if0.load_ready, if1.load_ready}, 32'd3);
        clk1();
        clk1();
        rst_n = 1'b1;
        clk1();
        check_val("c3_no_done0", n_done0 - base0, 32'd0);
        check_val("c3_no_done1", n_done1 - base1, 32'd0);
        load_word(8'h3C);
        send_check(8'h3C, 8, "w3c");
        finish_word("w3c", 1);

        // 55 then AA back-to-back with load_valid held high.
        din        = 8'h55;
        load_valid = 1'b1;
        clk1();
        base0 = n_done0;
        base1 = n_done1;
        din   = 8'hAA;
        send_check(8'h55, 8, "b55");
        clk1();
        load_valid = 1'b0;
        check_val("b2b_capture_busy", {30'd0, if0.busy, if1.busy}, 32'd3);
        check_val("b2b_capture_done", {30'd0, if0.done, if1.done}, 32'd0);
        send_check(8'hAA, 8, "baa");
        finish_word("baa", 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
